// File: rtl/tsp_opt_ctrl_if.sv
// tsp_opt_ctrl_if: start/done handshake between the tour sequencer and the swap evaluator
//   eval_start  master->slave  one-cycle pulse, eval_ids valid from this cycle until eval_done
//   eval_ids    master->slave  {path[v1-1],path[v1],path[v1+1],path[v2-1],path[v2],path[v2+1]}
//   eval_done   slave->master  single-cycle result strobe
//   eval_swap   slave->master  verdict, valid with eval_done
interface tsp_opt_ctrl_if #(parameter int IDW = 6);
    logic             eval_start;
    logic [6*IDW-1:0] eval_ids;
    logic             eval_done;
    logic             eval_swap;
    modport master (output eval_start, eval_ids, input eval_done, eval_swap);
    modport slave  (input eval_start, eval_ids, output eval_done, eval_swap);
endinterface

// File: rtl/tsp_opt_ctrl.sv
// tsp_opt_ctrl: TSP local-search sequencer owning the tour array and driving the swap evaluator
//   clk, rst            clock, asynchronous active-high reset
//   start, graph_ready  run request pulse, graph generator finished (level)
//   rnd_val             free-running random source, one draw per cycle
//   ev                  evaluator handshake (master side)
//   busy, done          running, finished (held until next start)
//   timeout_err         evaluator never answered; sticky until rst
//   iter_count          evaluated iterations this run; swap_count: committed swaps this run
//   rd_addr, rd_data    combinational tour read port
module tsp_opt_ctrl #(
    parameter int N            = 64,
    parameter int IDW          = 6,
    parameter int MAX_ITER     = 100000,
    parameter int STALL_LIMIT  = 4096,
    parameter int EVAL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              graph_ready,
    input  logic [31:0]       rnd_val,
    tsp_opt_ctrl_if.master    ev,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [31:0]       iter_count,
    output logic [31:0]       swap_count,
    input  logic [IDW-1:0]    rd_addr,
    output logic [IDW-1:0]    rd_data
);
    localparam logic [3:0] IDLE = 4'd0, INIT = 4'd1, WAITG = 4'd2, PICK1 = 4'd3, PICK2 = 4'd4,
                           CHECK = 4'd5, ISSUE = 4'd6, WAIT = 4'd7, COMMIT = 4'd8, DONE = 4'd9,
                           ERR = 4'd10;
    localparam int TW = $clog2(EVAL_TIMEOUT + 1);

    logic [3:0]     state;
    logic [IDW-1:0] path [N];
    logic [IDW-1:0] v1, v2, idx, draw;
    logic [TW-1:0]  tmo;
    logic [31:0]    stall, iter_nx, stall_nx;
    logic           verdict, far, stop;

    always_comb begin
        draw        = IDW'(rnd_val % 32'(N - 2) + 32'd1);
        far         = (v1 > v2 ? v1 - v2 : v2 - v1) > IDW'(1);
        iter_nx     = iter_count + {31'd0, ~&iter_count};
        stall_nx    = verdict ? 32'd0 : stall + {31'd0, ~&stall};
        stop        = iter_nx == 32'(MAX_ITER) || stall_nx == 32'(STALL_LIMIT);
        busy        = state != IDLE && state != DONE && state != ERR;
        done        = state == DONE;
        timeout_err = state == ERR;
        rd_data     = path[rd_addr];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            v1            <= '0;
            v2            <= '0;
            tmo           <= '0;
            stall         <= '0;
            verdict       <= 1'b0;
            iter_count    <= '0;
            swap_count    <= '0;
            ev.eval_start <= 1'b0;
            ev.eval_ids   <= '0;
        end else begin
            ev.eval_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= INIT;
                    idx        <= '0;
                    iter_count <= '0;
                    swap_count <= '0;
                    stall      <= '0;
                end
                INIT: begin
                    idx <= idx + IDW'(1);
                    if (idx == IDW'(N - 1)) state <= WAITG;
                end
                WAITG: if (graph_ready) state <= PICK1;
                PICK1: begin
                    v1    <= draw;
                    state <= PICK2;
                end
                PICK2: begin
                    v2    <= draw;
                    state <= CHECK;
                end
                // ids are loaded here so they are already valid during the eval_start cycle
                CHECK: if (far) begin
                    state         <= ISSUE;
                    ev.eval_start <= 1'b1;
                    ev.eval_ids   <= {path[v1 - IDW'(1)], path[v1], path[v1 + IDW'(1)],
                                      path[v2 - IDW'(1)], path[v2], path[v2 + IDW'(1)]};
                end else state <= PICK1;
                ISSUE: begin
                    state <= WAIT;
                    tmo   <= '0;
                end
                // ERR lands exactly EVAL_TIMEOUT cycles after the eval_start pulse
                WAIT: if (ev.eval_done) begin
                    verdict <= ev.eval_swap;
                    state   <= COMMIT;
                end else if (tmo == TW'(EVAL_TIMEOUT - 2)) state <= ERR;
                else tmo <= tmo + TW'(1);
                COMMIT: begin
                    iter_count <= iter_nx;
                    stall      <= stall_nx;
                    if (verdict) swap_count <= swap_count + {31'd0, ~&swap_count};
                    state <= stop ? DONE : PICK1;
                end
                DONE: if (start) begin
                    state      <= PICK1;
                    iter_count <= '0;
                    swap_count <= '0;
                    stall      <= '0;
                end
                default: ;
            endcase
        end

    // tour storage is not reset; a reset simply stops all writes until the next INIT
    always_ff @(posedge clk)
        if (state == INIT) path[idx] <= idx;
        else if (state == COMMIT && verdict) begin
            path[v1] <= path[v2];
            path[v2] <= path[v1];
        end
endmodule
